// File: rtl/acc_feed_sequencer.sv
// Accumulator feed sequencer: walks clear, term, bias and wait phases,
// streaming RAM terms and bias to the accumulator and capturing its sum.
module acc_feed_sequencer #(
    parameter int N_INPUTS     = 4,
    parameter int HOLD_CYCLES  = 7,
    parameter int CLEAR_CYCLES = 2,
    parameter int RESULT_WAIT  = 1,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [31:0]       bias_in,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       counter,
    output logic [31:0]       value_out,
    output logic [31:0]       bias_out,
    input  logic [31:0]       acc_result,
    output logic [31:0]       result,
    output logic              result_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_BIAS,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [31:0] LP_N        = 32'(N_INPUTS);
    localparam logic [31:0] LP_BIAS_IDX = 32'(N_INPUTS + 1);
    localparam logic [31:0] LP_HOLD_END = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] LP_HOLD_RD  = 32'(HOLD_CYCLES - 2);
    localparam logic [31:0] LP_CLR_END  = 32'(CLEAR_CYCLES - 1);
    localparam logic [31:0] LP_CLR_RD   = 32'(CLEAR_CYCLES - 2);
    localparam logic [31:0] LP_WAIT_END = 32'(RESULT_WAIT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_hold;
    logic [31:0]       w_hold_nxt;
    logic [31:0]       r_idx;
    logic [31:0]       w_idx_nxt;

    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_counter;
    logic [31:0]       r_value;
    logic [31:0]       r_bias;
    logic [31:0]       r_result;
    logic              r_result_valid;

    logic              w_busy;
    logic              w_done;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_counter;
    logic [31:0]       w_value;
    logic [31:0]       w_bias;
    logic [31:0]       w_result;
    logic              w_result_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_hold         <= '0;
            r_idx          <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_rd_en        <= 1'b0;
            r_addr         <= '0;
            r_counter      <= '0;
            r_value        <= '0;
            r_bias         <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_hold         <= w_hold_nxt;
            r_idx          <= w_idx_nxt;
            r_busy         <= w_busy;
            r_done         <= w_done;
            r_rd_en        <= w_rd_en;
            r_addr         <= w_addr;
            r_counter      <= w_counter;
            r_value        <= w_value;
            r_bias         <= w_bias;
            r_result       <= w_result;
            r_result_valid <= w_result_valid;
        end
    end

    // DONE is a one-cycle non-IDLE state so a start alongside done is dropped
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_idx_nxt   = r_idx;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CLEAR;
                    w_hold_nxt  = '0;
                    w_idx_nxt   = '0;
                end
            end
            S_CLEAR: begin
                if (r_hold == LP_CLR_END) begin
                    w_state_nxt = S_FEED;
                    w_hold_nxt  = '0;
                    w_idx_nxt   = 32'd1;
                end else begin
                    w_hold_nxt = r_hold + 32'd1;
                end
            end
            S_FEED: begin
                if (r_hold == LP_HOLD_END) begin
                    w_hold_nxt = '0;
                    w_idx_nxt  = r_idx + 32'd1;
                    if (r_idx == LP_N) begin
                        w_state_nxt = S_BIAS;
                    end
                end else begin
                    w_hold_nxt = r_hold + 32'd1;
                end
            end
            S_BIAS: begin
                if (r_hold == LP_HOLD_END) begin
                    w_state_nxt = S_WAIT;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold + 32'd1;
                end
            end
            S_WAIT: begin
                if (r_hold == LP_WAIT_END) begin
                    w_state_nxt = S_DONE;
                    w_hold_nxt  = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_hold_nxt = r_hold + 32'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_hold_nxt  = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every port is a flop
    always_comb begin
        w_busy         = 1'b0;
        w_counter      = '0;
        w_value        = '0;
        w_rd_en        = 1'b0;
        w_addr         = r_addr;
        w_bias         = r_bias;
        w_result       = r_result;
        w_result_valid = 1'b0;
        w_done         = 1'b0;

        if (r_state == S_IDLE && start) begin
            w_bias = bias_in;
        end

        unique case (w_state_nxt)
            S_CLEAR: begin
                w_busy = 1'b1;
                if (w_hold_nxt == LP_CLR_RD) begin
                    w_rd_en = 1'b1;
                    w_addr  = '0;
                end
            end
            S_FEED: begin
                w_busy    = 1'b1;
                w_counter = w_idx_nxt;
                w_value   = (w_hold_nxt == '0) ? mem_rdata : r_value;
                if (w_idx_nxt < LP_N && w_hold_nxt == LP_HOLD_RD) begin
                    w_rd_en = 1'b1;
                    w_addr  = w_idx_nxt[ADDR_W-1:0];
                end
            end
            S_BIAS, S_WAIT: begin
                w_busy    = 1'b1;
                w_counter = LP_BIAS_IDX;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase

        if (r_state == S_WAIT && w_state_nxt == S_DONE) begin
            w_result       = acc_result;
            w_result_valid = 1'b1;
            w_done         = 1'b1;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign mem_rd_en    = r_rd_en;
    assign mem_addr     = r_addr;
    assign counter      = r_counter;
    assign value_out    = r_value;
    assign bias_out     = r_bias;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_acc_feed_sequencer.sv
// Directed bench for acc_feed_sequencer: default instance plus a
// minimal-parameter instance, checked against hand-built schedules.
module tb_acc_feed_sequencer;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        a_start, a_busy, a_done, a_rd_en, a_rv;
    logic [7:0]  a_addr;
    logic [31:0] a_bias_in, a_rdata, a_counter, a_value, a_bias_out;
    logic [31:0] a_acc, a_result;

    logic        b_start, b_busy, b_done, b_rd_en, b_rv;
    logic [7:0]  b_addr;
    logic [31:0] b_bias_in, b_rdata, b_counter, b_value, b_bias_out;
    logic [31:0] b_acc, b_result;

    acc_feed_sequencer u_a (
        .clk(clk), .rstn(rstn), .start(a_start), .bias_in(a_bias_in),
        .busy(a_busy), .done(a_done), .mem_rd_en(a_rd_en),
        .mem_addr(a_addr), .mem_rdata(a_rdata), .counter(a_counter),
        .value_out(a_value), .bias_out(a_bias_out),
        .acc_result(a_acc), .result(a_result), .result_valid(a_rv)
    );

    acc_feed_sequencer #(
        .N_INPUTS(1), .HOLD_CYCLES(2), .CLEAR_CYCLES(2),
        .RESULT_WAIT(1), .ADDR_W(8)
    ) u_b (
        .clk(clk), .rstn(rstn), .start(b_start), .bias_in(b_bias_in),
        .busy(b_busy), .done(b_done), .mem_rd_en(b_rd_en),
        .mem_addr(b_addr), .mem_rdata(b_rdata), .counter(b_counter),
        .value_out(b_value), .bias_out(b_bias_out),
        .acc_result(b_acc), .result(b_result), .result_valid(b_rv)
    );

    logic [31:0] ram_a [4];
    logic [7:0]  rd_q [$];

    // RAM data is only meaningful the cycle after a read strobe
    always @(posedge clk) begin
        if (a_rd_en && a_addr < 8'd4) a_rdata <= ram_a[a_addr[1:0]];
        else                          a_rdata <= 32'hDEADBEEF;
        if (b_rd_en && b_addr == 8'd0) b_rdata <= 32'h12345678;
        else                           b_rdata <= 32'hDEADBEEF;
    end

    always @(negedge clk) if (a_rd_en) rd_q.push_back(a_addr);

    typedef struct {
        int          reps;
        logic [31:0] cnt;
        logic [31:0] val;
        int          rd_at;
        logic [7:0]  rd_addr;
    } seg_t;

    seg_t segs_a [6];
    seg_t segs_b [3];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_a_idle(input string name);
        chk({name, "_flags"}, {28'd0, a_busy, a_done, a_rd_en, a_rv}, 32'd0);
        chk({name, "_counter"}, a_counter, 32'd0);
        chk({name, "_value"}, a_value, 32'd0);
    endtask

    // Caller has set a_start=1 at a negedge; walks the 39-cycle schedule
    task automatic walk_a(input logic [31:0] bias, input int p1,
                          input int p2, input logic [31:0] exp_res);
        int j = 0;
        for (int s = 0; s < 6; s++) begin
            for (int p = 0; p < segs_a[s].reps; p++) begin
                @(negedge clk);
                j++;
                a_start = (j == p1 || j == p2);
                if (j == 1) a_bias_in = 32'hBAD0BAD0;
                chk("counter", a_counter, segs_a[s].cnt);
                chk("value_out", a_value, segs_a[s].val);
                chk("rd_en", {31'd0, a_rd_en},
                    {31'd0, (p == segs_a[s].rd_at)});
                if (p == segs_a[s].rd_at)
                    chk("mem_addr", {24'd0, a_addr}, {24'd0, segs_a[s].rd_addr});
                chk("busy_run", {31'd0, a_busy}, 32'd1);
                chk("rv_early", {31'd0, a_rv}, 32'd0);
            end
        end
        @(negedge clk);
        a_start = 1'b0;
        chk("rv_at_L", {31'd0, a_rv}, 32'd1);
        chk("done_at_L", {31'd0, a_done}, 32'd1);
        chk("result", a_result, exp_res);
        chk("busy_done", {31'd0, a_busy}, 32'd0);
        chk("counter_done", a_counter, 32'd0);
        chk("bias_out", a_bias_out, bias);
    endtask

    task automatic chk_reads_a;
        chk("rd_count", rd_q.size(), 4);
        for (int i = 0; i < 4 && i < rd_q.size(); i++)
            chk("rd_order", {24'd0, rd_q[i]}, i);
    endtask

    initial begin
        int j, found, nrv, nruns, last_done;

        ram_a[0] = 32'h3F800000; ram_a[1] = 32'h40000000;
        ram_a[2] = 32'h40400000; ram_a[3] = 32'h40800000;
        segs_a[0] = '{2, 32'd0, 32'h0, 0, 8'd0};
        segs_a[1] = '{7, 32'd1, 32'h3F800000, 5, 8'd1};
        segs_a[2] = '{7, 32'd2, 32'h40000000, 5, 8'd2};
        segs_a[3] = '{7, 32'd3, 32'h40400000, 5, 8'd3};
        segs_a[4] = '{7, 32'd4, 32'h40800000, -1, 8'd0};
        segs_a[5] = '{8, 32'd5, 32'h0, -1, 8'd0};
        segs_b[0] = '{2, 32'd0, 32'h0, 0, 8'd0};
        segs_b[1] = '{2, 32'd1, 32'h12345678, -1, 8'd0};
        segs_b[2] = '{3, 32'd2, 32'h0, -1, 8'd0};

        rstn = 1'b0; a_start = 1'b0; b_start = 1'b0;
        a_bias_in = 32'h0; b_bias_in = 32'h0;
        a_acc = 32'h41300000; b_acc = 32'hCAFEF00D;

        // reset then idle
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_a_idle("idle");
            chk("idle_regs", a_bias_out | a_result | {24'd0, a_addr}, 32'd0);
            chk("idle_b", {b_busy, b_rd_en, b_rv, b_counter[28:0]}, 32'd0);
        end

        // default run
        rd_q.delete();
        a_bias_in = 32'h3F000000; a_start = 1'b1;
        walk_a(32'h3F000000, 0, 0, 32'h41300000);
        chk_reads_a();

        // extra starts while busy are ignored
        repeat (2) @(negedge clk);
        rd_q.delete();
        a_bias_in = 32'h3E800000; a_start = 1'b1;
        walk_a(32'h3E800000, 5, 20, 32'h41300000);
        nrv = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (a_rv) nrv++;
        end
        chk("ignored_starts_rv", nrv, 0);
        chk("ignored_starts_bias", a_bias_out, 32'h3E800000);
        chk_reads_a();

        // reset mid-FEED
        a_bias_in = 32'h11111111; a_start = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            @(negedge clk);
            a_start = 1'b0;
            if (a_counter == 32'd2) found = 1;
        end
        chk("reached_idx2", found, 1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk_a_idle("rst_mid");
        chk("rst_bias", a_bias_out, 32'd0);
        nrv = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (a_rv || a_busy || a_rd_en) nrv++;
        end
        chk("rst_quiet", nrv, 0);
        rd_q.delete();
        a_bias_in = 32'h22222222; a_start = 1'b1;
        walk_a(32'h22222222, 0, 0, 32'h41300000);
        chk_reads_a();

        // minimal parameter corner on the second instance
        @(negedge clk);
        b_bias_in = 32'h33333333; b_start = 1'b1;
        j = 0;
        for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < segs_b[s].reps; p++) begin
                @(negedge clk);
                j++;
                b_start = 1'b0;
                chk("b_counter", b_counter, segs_b[s].cnt);
                chk("b_value", b_value, segs_b[s].val);
                chk("b_rd_en", {31'd0, b_rd_en},
                    {31'd0, (p == segs_b[s].rd_at)});
                chk("b_rv_early", {31'd0, b_rv}, 32'd0);
            end
        end
        @(negedge clk);
        chk("b_cycle", j + 1, 8);
        chk("b_rv", {31'd0, b_rv}, 32'd1);
        chk("b_done", {31'd0, b_done}, 32'd1);
        chk("b_result", b_result, 32'hCAFEF00D);
        chk("b_bias_out", b_bias_out, 32'h33333333);
        chk("b_addr", {24'd0, b_addr}, 32'd0);

        // back-to-back with start held high
        repeat (3) @(negedge clk);
        rd_q.delete();
        a_acc = 32'h42000000;
        a_bias_in = 32'h44444444; a_start = 1'b1;
        nruns = 0; last_done = -10;
        for (int jj = 1; jj <= 200 && nruns < 3; jj++) begin
            @(negedge clk);
            if (jj == last_done + 1)
                chk("b2b_gap_busy", {31'd0, a_busy}, 32'd0);
            if (jj == last_done + 2)
                chk("b2b_restart_busy", {31'd0, a_busy}, 32'd1);
            if (a_rv) begin
                chk("b2b_cycle", jj, 39 + 40 * nruns);
                chk("b2b_result", a_result, a_acc);
                nruns++;
                last_done = jj;
                a_acc = a_acc + 32'h00100000;
                if (nruns == 3) a_start = 1'b0;
            end
        end
        chk("b2b_runs", nruns, 3);
        chk("b2b_reads", rd_q.size(), 12);
        repeat (3) @(negedge clk);
        chk("b2b_stop", {31'd0, a_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_feed_sequencer.md
Name: acc_feed_sequencer

Overview:
Initiator side of the neuron accumulator interface.
- On a start pulse it drives the index `counter`, one pre-multiplied term per index (read from a synchronous term RAM) and the neuron bias, in the schedule the accumulator consumes.
- It then samples the accumulator's `value_out` and returns one 32-bit IEEE-754 neuron sum with a valid pulse.
- It sits between the layer controller/term RAM and the accumulator, one instance per neuron lane.

Parameters:
- N_INPUTS, 4: number of terms per neuron. Must equal the accumulator's COUNTER_END. 1..2^ADDR_W.
- HOLD_CYCLES, 7: cycles each index (including the bias index) is held on `counter`. Covers FPU add latency. Minimum 2.
- CLEAR_CYCLES, 2: cycles `counter`=0 is held before index 1 to clear the accumulator. Minimum 2.
- RESULT_WAIT, 1: cycles after the bias phase, `counter` held at N_INPUTS+1, before sampling `acc_result`. Minimum 1.
- ADDR_W, 8: term RAM address width.

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- start  in  1  begin one neuron sum; sampled only in IDLE
- bias_in  in  32  neuron bias, latched on the accepted start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse, same cycle as result_valid
- mem_rd_en  out  1  term RAM read strobe
- mem_addr  out  ADDR_W  term RAM address, term k at address k-1
- mem_rdata  in  32  term RAM data, valid exactly 1 cycle after mem_rd_en
- counter  out  32  index to accumulator: 0 = clear, 1..N_INPUTS = terms, N_INPUTS+1 = bias
- value_out  out  32  current term to accumulator `value_in`
- bias_out  out  32  latched bias to accumulator `bias`
- acc_result  in  32  accumulator `value_out`
- result  out  32  sampled neuron sum, holds until next capture
- result_valid  out  1  one-cycle pulse when `result` updates

Behaviour:
- Reset (rstn=0 at an edge, from any state): state IDLE, all outputs 0, hold and index counters 0. Reset mid-operation aborts with no done or result_valid pulse.
- All outputs are registered.
- IDLE:
  - `counter`=0, busy=0.
  - start=1 at an edge: bias_out<=bias_in, go to CLEAR.
  - start while busy=1 is ignored (no queueing).
- CLEAR:
  - Lasts CLEAR_CYCLES cycles with `counter`=0 and value_out=0.
  - In cycle CLEAR_CYCLES-1: mem_rd_en=1, mem_addr=0.
  - At the edge ending the last CLEAR cycle: counter<=1, value_out<=mem_rdata, go to FEED.
- FEED, index k:
  - `counter`=k and value_out held for exactly HOLD_CYCLES cycles.
  - If k<N_INPUTS: in hold cycle HOLD_CYCLES-1 (1-based), mem_rd_en=1 and mem_addr=k. At the edge ending hold cycle HOLD_CYCLES, counter<=k+1 and value_out<=mem_rdata in the same edge.
  - If k=N_INPUTS: no read. counter<=N_INPUTS+1, value_out<=0, go to BIAS.
  - mem_rd_en is 0 in every other cycle.
- BIAS: `counter`=N_INPUTS+1 for HOLD_CYCLES cycles, then WAIT.
- WAIT:
  - `counter` stays N_INPUTS+1 for RESULT_WAIT cycles.
  - At the edge ending the last cycle: result<=acc_result, result_valid<=1, done<=1, counter<=0, value_out<=0, busy<=0, go to IDLE.
- result_valid and done are high exactly one cycle.
- A start asserted in the same cycle as done is ignored, because the state is not IDLE. Earliest restart is the following cycle.
- Latency: result_valid is high in cycle L = CLEAR_CYCLES + (N_INPUTS+1)*HOLD_CYCLES + RESULT_WAIT + 1 after the accepting edge. Defaults give L=39.
- Total RAM reads per neuron = N_INPUTS. Addresses 0..N_INPUTS-1 in order, no wrap.
- bias_in changes after acceptance do not affect the running sum. bias_out changes only on accepted start or reset.
- No arithmetic on data. Terms and bias pass through bit-exact.

Test Plan:
- Reset then idle: rstn=0 for 2 cycles, then 1 → all outputs 0, counter=0, no mem_rd_en for 20 cycles.
- Default run: RAM = {3F800000, 40000000, 40400000, 40800000}, bias_in=3F000000, start 1 cycle, acc_result model returns 41300000.
  - counter sequence: 0×2, 1×7, 2×7, 3×7, 4×7, 5×8.
  - value_out matches RAM per index.
  - Reads at addresses 0..3 only.
  - result=41300000, result_valid and done high once, 39 cycles after start.
- Start ignored while busy: second start pulses at cycles 5 and 20 → one result only; bias_out keeps the first bias.
- Reset mid-FEED: rstn=0 while counter=2 → next cycle all outputs 0, IDLE, no result_valid. A new start runs the full sequence from address 0.
- Parameter corner: N_INPUTS=1, HOLD_CYCLES=2, CLEAR_CYCLES=2, RESULT_WAIT=1 → counter 0,0,1,1,2,2,2; single read at address 0; result_valid at cycle 8.
- Back-to-back: start held high continuously → new run accepted the cycle after each done. Runs separated by exactly 1 IDLE cycle; results equal per-run acc_result.
